// File: rtl/clk_div_ctrl.sv
// Run-time divider controller: owns the divide ratio, produces a registered
// divided clock plus a once-per-period tick, and swaps ratios only on wrap edges.
module clk_div_ctrl #(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] cur_div
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_div, r_pend_div, r_counter;
  logic                 r_pend, r_clk, r_tick, r_done, r_err;

  logic w_ready, w_accept, w_zero, w_wrap;

  assign w_ready  = (r_state == ST_STOP) || ((r_state == ST_RUN) && !r_pend);
  assign w_accept = cfg_valid && w_ready;
  assign w_zero   = (cfg_div == '0);
  assign w_wrap   = (r_counter == (r_div - CNT_WIDTH'(1)));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state    <= ST_STOP;
      r_div      <= CNT_WIDTH'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_counter  <= '0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      r_err  <= w_accept && w_zero;
      case (r_state)
        ST_STOP: begin
          r_counter <= '0;
          r_clk     <= 1'b0;
          // Catches a divisor accepted on the very edge that left RUN.
          if (r_pend) begin
            r_div  <= r_pend_div;
            r_pend <= 1'b0;
            r_done <= 1'b1;
          end
          if (w_accept && !w_zero) begin
            r_div  <= cfg_div;
            r_done <= 1'b1;
          end
          if (enable) r_state <= ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (w_wrap) begin
            r_counter <= '0;
            r_tick    <= 1'b1;
            r_clk     <= ~r_clk;
            if (r_pend) begin
              r_div  <= r_pend_div;
              r_pend <= 1'b0;
              r_done <= 1'b1;
            end
          end else begin
            r_counter <= r_counter + CNT_WIDTH'(1);
          end

          if ((r_state == ST_RUN) && !enable && !r_clk) begin
            // Low phase already: stop at once, no tick, pending divisor lands now.
            r_state   <= ST_STOP;
            r_counter <= '0;
            r_tick    <= 1'b0;
            r_clk     <= 1'b0;
            if (r_pend) begin
              r_div  <= r_pend_div;
              r_pend <= 1'b0;
              r_done <= 1'b1;
            end
          end else if (r_clk && w_wrap && ((r_state == ST_DRAIN) || !enable)) begin
            r_state <= ST_STOP;
          end else if ((r_state == ST_RUN) && !enable) begin
            r_state <= ST_DRAIN;
          end

          if ((r_state == ST_RUN) && w_accept && !w_zero) begin
            r_pend_div <= cfg_div;
            r_pend     <= 1'b1;
          end
        end
        default: r_state <= ST_STOP;
      endcase
    end
  end

  assign cfg_ready = w_ready;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign clk_out   = r_clk;
  assign tick      = r_tick;
  assign running   = (r_state != ST_STOP);
  assign cur_div   = r_div;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the pixel-clock divider path: it owns the divide ratio, starts and stops the divided clock, and applies new ratios without glitches. It produces a registered divided clock `clk_out` and a one-cycle `tick` clock-enable. Both feed the video timing logic downstream. Divisor changes arrive through a valid/ready handshake and take effect only at a period boundary, so `clk_out` never shows a runt pulse.

## Interface
Parameters:
- `CNT_WIDTH`, 8: width of divisor, counter and `cur_div`.
- `DEFAULT_DIV`, 2: divisor loaded at reset. Must be ≥1 and fit in `CNT_WIDTH`.

Ports:
- `clk_in`  input  1: single system clock. All logic is on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `enable`  input  1: level run request.
- `cfg_valid`  input  1: new-divisor request.
- `cfg_div`  input  CNT_WIDTH: requested divisor.
- `cfg_ready`  output  1: request can be accepted this cycle.
- `cfg_done`  output  1: one-cycle pulse when an accepted divisor becomes active.
- `cfg_err`  output  1: one-cycle pulse when `cfg_div`==0 is accepted.
- `clk_out`  output  1: divided clock; toggles on each tick.
- `tick`  output  1: one-cycle enable, once per divisor period.
- `running`  output  1: high in RUN or DRAIN.
- `cur_div`  output  CNT_WIDTH: active divisor.

## Operation
- States:
  - STOP (reset state)
  - RUN
  - DRAIN
- Registers:
  - `div` (active divisor)
  - `pend_div` and `pend` flag
  - `counter` (CNT_WIDTH)
- STOP:
  - Holds `counter`=0, `clk_out`=0, `tick`=0.
  - `enable`=1 moves to RUN with `counter`<=0.
- RUN:
  - When `counter`==`div`-1: `counter`<=0, `tick`<=1, `clk_out`<=~`clk_out`.
  - Otherwise: `counter`+1 and `tick`<=0.
- RUN with `enable`=0:
  - If `clk_out`==0, go to STOP at the next edge.
  - Otherwise go to DRAIN; the same edge still performs the RUN count/wrap.
- DRAIN:
  - Keeps counting like RUN.
  - The wrap edge that drives `clk_out` to 0 also enters STOP, and `tick` pulses for that final edge.
  - `enable` returning to 1 in DRAIN does not abort the drain; the block re-enters RUN from STOP.
- `cfg_ready` = (state==STOP) or (state==RUN and !`pend`). It is low in DRAIN and while a divisor is pending.
- Accept means `cfg_valid` & `cfg_ready` at an edge:
  - `cfg_div`==0: `cfg_err` pulses next cycle; `div` and `pend` are unchanged.
  - In STOP: `div`<=`cfg_div` at the accept edge; `cfg_done` pulses the next cycle.
  - In RUN: `pend_div`<=`cfg_div`, `pend`<=1. At the next wrap edge, `div`<=`pend_div`, `pend`<=0, `cfg_done`<=1, and `counter`<=0. `cfg_done` therefore coincides with `tick`.
- A pending divisor survives a RUN→DRAIN→STOP transition:
  - If still pending when STOP is entered, it is applied on the STOP-entry edge, with `cfg_done` pulsing the next cycle.
- `cur_div` = `div`. `running` = state!=STOP.
- `div`==1: `tick` is high every cycle after the first RUN cycle, and `clk_out` toggles every cycle.

## Timing
- Reset values:
  - state STOP, `counter`=0, `div`=DEFAULT_DIV, `pend`=0
  - `clk_out`=0, `tick`=0, `cfg_done`=0, `cfg_err`=0
  - `running`=0, `cfg_ready`=1
- Reset mid-operation clears everything immediately (asynchronously), including any pending divisor.
- Start latency:
  - `enable` sampled high at edge E enters RUN.
  - The first `tick` and `clk_out` rise are registered at edge E+`div`.
- `clk_out` period = 2×`div` cycles, with 50% duty. `tick` period = `div` cycles.
- Divisor change: the new divisor applies from the wrap edge, so the next tick comes `new_div` edges later. There are no partial periods.
- All outputs are registered except `cfg_ready`, `running` and `cur_div`, which are decoded from registers only (no input-to-output combinational path).
- Counter arithmetic is unsigned CNT_WIDTH. The compare is `counter`==`div`-1, and no overflow is possible for `div`≥1.

## Test plan
- Reset release then `enable`=1 with DEFAULT_DIV=2 -> `tick` every 2 cycles; `clk_out` period 4; first rise 2 edges after `enable` is sampled; `running`=1.
- In RUN at `div`=2, accept `cfg_div`=5 mid-period -> `cfg_ready` low until the wrap; `cfg_done` and `tick` coincide; next ticks are 5 cycles apart; `cur_div`=5.
- In STOP, accept `cfg_div`=0 -> `cfg_err` one-cycle pulse; `cur_div` unchanged; no `cfg_done`.
- `enable`=0 while `clk_out`=1 at `div`=3 -> DRAIN, `cfg_ready`=0; STOP on the edge where `clk_out` falls; `clk_out` high phase is a full 3 cycles; then `running`=0.
- `div`=1 run -> `tick` continuously high and `clk_out` toggles every cycle; `enable`=0 -> stops with `clk_out`=0 within 2 cycles.
- Assert `reset` with a divisor pending and `clk_out`=1 -> all outputs at reset values immediately; after release `cur_div`=DEFAULT_DIV and no `cfg_done`.
